mpu_event_fifo: RTL and testbench
=================================

Name: mpu_event_fifo

Overview:
Downstream consumer of the MPU user-event outputs (user_irq, user_data). Each user_irq rising edge captures the 64-bit user_data word into a FIFO. The CPU drains the FIFO through a CSR window. A level interrupt is raised while events are pending, so no MPU notification is lost when software is slow.

Parameters:
csr_addr, 4'h0, CSR bank select; the block responds when csr_a[13:10] == csr_addr.
depth_log2, 4, FIFO depth is 2**depth_log2 entries (16 by default).

Ports:
sys_clk  in  1  system clock; the only clock.
sys_rst  in  1  asynchronous, active-low reset.
csr_a  in  14  CSR address: [13:10] bank, [2:0] register.
csr_we  in  1  CSR write strobe.
csr_di  in  32  CSR write data.
csr_do  out  32  CSR read data, registered.
user_irq  in  1  MPU event strobe, on the mpu_clk (sys_clk/2) cadence; may stay high 2+ cycles.
user_data  in  64  MPU event payload, stable while user_irq is high.
irq  out  1  level interrupt: pending & irq_en.

Behaviour:
- Reset (sys_rst low, asynchronous): FIFO empty, overflow=0, drops=0, cap_en=0, irq_en=0, csr_do=0, irq=0, edge register=0.
- Capture:
  - push = user_irq & ~user_irq_q & cap_en, where user_irq_q is user_irq registered one cycle. One push per event regardless of pulse width.
  - user_data is sampled in the same cycle as push.
- Register map (reg = csr_a[2:0], selected only when the bank matches):
  - 0 STATUS (R): [depth_log2:0] count, [16] empty, [17] full, [18] overflow (sticky). Write with di[18]=1 clears overflow.
  - 1 DATA_LO (R): head[31:0]. Reading has no side effect.
  - 2 DATA_HI (R): head[63:32]. Any write pops one entry.
  - 3 CTRL (R/W): [0] cap_en, [1] irq_en. di[2]=1 flushes the FIFO (self-clearing, reads 0).
  - 4 DROPS (R): 16-bit saturating dropped-event counter. Any write clears it.
  - 5–7: read 0, writes ignored.
- CSR read latency is 1 cycle: csr_do is registered from csr_a each cycle. When the bank does not match, csr_do=0 the next cycle.
- Empty FIFO: DATA_LO/DATA_HI read 0; pop is ignored and count stays 0.
- Full FIFO:
  - Push alone: entry dropped, overflow set, drops incremented (saturates at 16'hFFFF).
  - Push and pop in the same cycle: both take effect, count unchanged, no overflow.
- Non-full, push and pop in the same cycle: count unchanged. The data order is preserved.
- Flush in the same cycle as a push: flush wins, the pushed word is discarded and not counted as a drop. Flush does not clear overflow or drops.
- Pointers: depth_log2-bit read/write pointers wrap modulo depth. count is (depth_log2+1) bits wide, range 0..depth.
- Head data is visible on DATA_LO/DATA_HI one cycle after a push into an empty FIFO.
- irq = (count != 0) & irq_en, registered. It deasserts the cycle after the pop that empties the FIFO.
- Reset mid-operation discards all entries immediately; there is no partial-state retention.

Decomposition:
- Shared package mpu_event_pkg holds:
  - register index constants: REG_STATUS=0, REG_DATA_LO=1, REG_DATA_HI=2, REG_CTRL=3, REG_DROPS=4;
  - STATUS bit positions;
  - the DROPS width (16).
- One sub-module, mpu_event_fifo_mem: dual-pointer register array, 64-bit wide, with push/pop/flush inputs and head/count/full/empty outputs.
- The top level holds edge detection, the CSR decode and the counters.

Test Plan:
- Basic capture: enable cap_en=1, irq_en=1; user_irq high 2 cycles with user_data=64'h0123_4567_89AB_CDEF -> STATUS count=1, empty=0; irq=1; DATA_LO=32'h89ABCDEF, DATA_HI=32'h01234567; write DATA_HI -> count=0, irq=0 one cycle later.
- Ordering and wrap: push 20 events (data=i), popping after each 10th push -> values read back in order 0..19, across pointer wrap; count never exceeds 16.
- Overflow: 18 pushes with no pops -> count=16, full=1, overflow=1, DROPS=2; head=first value; write STATUS di[18]=1 -> overflow=0, DROPS still 2.
- Simultaneous full push+pop: fill to 16, then push and pop in the same cycle -> count=16, overflow=0, last entry is the new value.
- Edge cases: pop when empty -> count stays 0, DATA reads 0; flush with a concurrent push -> count=0, DROPS unchanged; cap_en=0 with user_irq pulses -> no capture.
- Reset mid-stream: 5 entries queued, assert sys_rst asynchronously between clock edges -> count=0, irq=0 and csr_do=0 immediately; CTRL reads 0 after release.

Source files
------------

// File: rtl/mpu_event_pkg.sv
// Shared constants for the MPU user-event FIFO: CSR register indices,
// STATUS/CTRL bit positions and the dropped-event counter width.
package mpu_event_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_DATA_LO = 3'd1;
    localparam logic [2:0] REG_DATA_HI = 3'd2;
    localparam logic [2:0] REG_CTRL    = 3'd3;
    localparam logic [2:0] REG_DROPS   = 3'd4;

    localparam int ST_EMPTY = 16;
    localparam int ST_FULL  = 17;
    localparam int ST_OVF   = 18;

    localparam int CTRL_CAP   = 0;
    localparam int CTRL_IRQ   = 1;
    localparam int CTRL_FLUSH = 2;

    localparam int DROPS_W = 16;

    function automatic logic bank_hit(
        input logic [13:0] a,
        input logic [3:0]  bank
    );
        return a[13:10] == bank;
    endfunction

endpackage

// File: rtl/mpu_event_fifo_if.sv
// CSR bus plus MPU event inputs and interrupt output of the event FIFO.
// master: CPU/MPU side driving the block; slave: the event FIFO itself.
interface mpu_event_fifo_if;

    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        user_irq;
    logic [63:0] user_data;
    logic        irq;

    modport master (
        output csr_a, csr_we, csr_di,
        output user_irq, user_data,
        input  csr_do, irq
    );

    modport slave (
        input  csr_a, csr_we, csr_di,
        input  user_irq, user_data,
        output csr_do, irq
    );

endinterface

// File: rtl/mpu_event_fifo_mem.sv
// 64-bit register-array FIFO with push/pop/flush.
// Ports: clk, rst_n, push, pop, flush, wdata in; head, count, full, empty out.
module mpu_event_fifo_mem #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [63:0]           wdata,
    output logic [63:0]           head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT =
        (DEPTH_LOG2 + 1)'(DEPTH);

    logic [63:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  wr_en;
    logic                  rd_en;

    always_comb begin
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);
        rd_en = pop & ~empty & ~flush;
        // a pop in the same cycle frees the slot a full FIFO needs
        wr_en = push & ~flush & (~full | rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_en && !rd_en) count_d = count_q + 1'b1;
            if (rd_en && !wr_en) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/mpu_event_fifo.sv
// Captures MPU user events into a FIFO drained via a CSR window.
// Ports: sys_clk, sys_rst (async, active-low), bus (CSR + events + irq).
module mpu_event_fifo
    import mpu_event_pkg::*;
#(
    parameter logic [3:0] csr_addr   = 4'h0,
    parameter int         depth_log2 = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    mpu_event_fifo_if.slave   bus
);

    logic               user_irq_q, user_irq_d;
    logic               cap_en_q, cap_en_d;
    logic               irq_en_q, irq_en_d;
    logic               overflow_q, overflow_d;
    logic [DROPS_W-1:0] drops_q, drops_d;
    logic [31:0]        csr_do_q, csr_do_d;
    logic               irq_q, irq_d;

    logic               sel;
    logic [2:0]         rg;
    logic               wr_status, wr_ctrl, wr_drops;
    logic               push, pop, flush, drop;
    logic [31:0]        rd_data;
    logic [63:0]        head_vis;

    logic [63:0]         head;
    logic [depth_log2:0] count;
    logic                full;
    logic                empty;

    mpu_event_fifo_mem #(
        .DEPTH_LOG2 (depth_log2)
    ) u_mem (
        .clk   (sys_clk),
        .rst_n (sys_rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (bus.user_data),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        sel       = bank_hit(bus.csr_a, csr_addr);
        rg        = bus.csr_a[2:0];
        wr_status = sel & bus.csr_we & (rg == REG_STATUS);
        wr_ctrl   = sel & bus.csr_we & (rg == REG_CTRL);
        wr_drops  = sel & bus.csr_we & (rg == REG_DROPS);
        pop       = sel & bus.csr_we & (rg == REG_DATA_HI);
        flush     = wr_ctrl & bus.csr_di[CTRL_FLUSH];
        // one push per rising edge, however long the strobe lasts
        push      = bus.user_irq & ~user_irq_q & cap_en_q;
        drop      = push & full & ~pop & ~flush;

        user_irq_d = bus.user_irq;
        cap_en_d   = wr_ctrl ? bus.csr_di[CTRL_CAP] : cap_en_q;
        irq_en_d   = wr_ctrl ? bus.csr_di[CTRL_IRQ] : irq_en_q;

        overflow_d = overflow_q;
        if (wr_status && bus.csr_di[ST_OVF]) overflow_d = 1'b0;
        if (drop) overflow_d = 1'b1;

        drops_d = wr_drops ? '0 : drops_q;
        if (drop && drops_d != '1) drops_d = drops_d + 1'b1;

        irq_d = (count != '0) & irq_en_q;

        head_vis = empty ? 64'h0 : head;

        rd_data = '0;
        case (rg)
            REG_STATUS: begin
                rd_data[depth_log2:0] = count;
                rd_data[ST_EMPTY]     = empty;
                rd_data[ST_FULL]      = full;
                rd_data[ST_OVF]       = overflow_q;
            end
            REG_DATA_LO: rd_data = head_vis[31:0];
            REG_DATA_HI: rd_data = head_vis[63:32];
            REG_CTRL: begin
                rd_data[CTRL_CAP] = cap_en_q;
                rd_data[CTRL_IRQ] = irq_en_q;
            end
            REG_DROPS: rd_data[DROPS_W-1:0] = drops_q;
            default: rd_data = '0;
        endcase

        csr_do_d = sel ? rd_data : 32'h0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            user_irq_q <= 1'b0;
            cap_en_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            drops_q    <= '0;
            csr_do_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            user_irq_q <= user_irq_d;
            cap_en_q   <= cap_en_d;
            irq_en_q   <= irq_en_d;
            overflow_q <= overflow_d;
            drops_q    <= drops_d;
            csr_do_q   <= csr_do_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.csr_do = csr_do_q;
    assign bus.irq    = irq_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.csr_a[9:3],
                         bus.csr_di[31:19], bus.csr_di[17:3]};

endmodule

// File: tb/tb_mpu_event_fifo.sv
// Directed, table-driven bench for mpu_event_fifo.
// Prints one summary line with passed/total check counts.
module tb_mpu_event_fifo;
    import mpu_event_pkg::*;

    localparam logic [3:0] BANK = 4'h0;

    typedef enum logic [2:0] {
        OP_RD, OP_WR, OP_EV, OP_IRQ, OP_RDX
    } op_e;

    typedef struct {
        op_e         op;
        logic [2:0]  rg;
        logic [31:0] di;
        logic [63:0] ev;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic sys_clk;
    logic sys_rst;

    mpu_event_fifo_if bus ();

    mpu_event_fifo #(
        .csr_addr   (BANK),
        .depth_log2 (4)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    vec_t tbl[$];

    function automatic vec_t mk(
        input op_e op, input logic [2:0] rg,
        input logic [31:0] di, input logic [63:0] ev,
        input logic [31:0] exp, input string name
    );
        vec_t v;
        v.op = op; v.rg = rg; v.di = di;
        v.ev = ev; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic check(
        input string name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic csr_wr(input logic [2:0] rg, input logic [31:0] di);
        bus.csr_a  = {BANK, 7'b0, rg};
        bus.csr_we = 1'b1;
        bus.csr_di = di;
        @(posedge sys_clk); #1;
        bus.csr_we = 1'b0;
        bus.csr_di = '0;
    endtask

    task automatic csr_rd(
        input logic [3:0] bank, input logic [2:0] rg,
        output logic [31:0] d
    );
        bus.csr_a  = {bank, 7'b0, rg};
        bus.csr_we = 1'b0;
        @(posedge sys_clk); #1;
        d = bus.csr_do;
    endtask

    task automatic ev(input logic [63:0] data);
        bus.user_irq  = 1'b1;
        bus.user_data = data;
        repeat (2) @(posedge sys_clk);
        #1;
        bus.user_irq = 1'b0;
        @(posedge sys_clk); #1;
    endtask

    logic [31:0] d;
    int mcount;
    int exp_next;

    initial begin
        sys_rst       = 1'b0;
        bus.csr_a     = '0;
        bus.csr_we    = 1'b0;
        bus.csr_di    = '0;
        bus.user_irq  = 1'b0;
        bus.user_data = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_csr_do", bus.csr_do, 32'h0);
        check("rst_irq", {31'b0, bus.irq}, 32'h0);
        #2 sys_rst = 1'b1;
        @(posedge sys_clk); #1;

        tbl.push_back(mk(OP_RD, REG_STATUS, 0, 0, 32'h10000, "rst_status"));
        tbl.push_back(mk(OP_RD, REG_CTRL, 0, 0, 32'h0, "rst_ctrl"));
        tbl.push_back(mk(OP_WR, REG_CTRL, 32'h3, 0, 0, "en"));
        tbl.push_back(mk(OP_RD, REG_CTRL, 0, 0, 32'h3, "ctrl_rd"));
        tbl.push_back(mk(OP_RDX, REG_CTRL, 0, 0, 32'h0, "bank_miss"));
        tbl.push_back(mk(OP_EV, 0, 0, 64'h0123_4567_89AB_CDEF, 0, "ev"));
        tbl.push_back(mk(OP_RD, REG_STATUS, 0, 0, 32'h1, "cap_status"));
        tbl.push_back(mk(OP_IRQ, 0, 0, 0, 32'h1, "cap_irq"));
        tbl.push_back(mk(OP_RD, REG_DATA_LO, 0, 0, 32'h89ABCDEF, "cap_lo"));
        tbl.push_back(mk(OP_RD, REG_DATA_HI, 0, 0, 32'h01234567, "cap_hi"));
        tbl.push_back(mk(OP_RD, REG_DATA_LO, 0, 0, 32'h89ABCDEF, "lo_again"));
        tbl.push_back(mk(OP_WR, REG_DATA_HI, 0, 0, 0, "pop"));
        tbl.push_back(mk(OP_RD, REG_STATUS, 0, 0, 32'h10000, "pop_status"));
        tbl.push_back(mk(OP_IRQ, 0, 0, 0, 32'h0, "pop_irq"));
        tbl.push_back(mk(OP_WR, REG_DATA_HI, 0, 0, 0, "pop_empty"));
        tbl.push_back(mk(OP_RD, REG_STATUS, 0, 0, 32'h10000, "empty_status"));
        tbl.push_back(mk(OP_RD, REG_DATA_LO, 0, 0, 32'h0, "empty_lo"));
        tbl.push_back(mk(OP_RD, REG_DATA_HI, 0, 0, 32'h0, "empty_hi"));
        tbl.push_back(mk(OP_WR, REG_CTRL, 32'h2, 0, 0, "cap_off"));
        tbl.push_back(mk(OP_EV, 0, 0, 64'h55, 0, "ev_off"));
        tbl.push_back(mk(OP_RD, REG_STATUS, 0, 0, 32'h10000, "off_status"));
        tbl.push_back(mk(OP_WR, REG_CTRL, 32'h3, 0, 0, "cap_on"));
        tbl.push_back(mk(OP_RD, REG_CTRL, 0, 0, 32'h3, "ctrl_back"));
        tbl.push_back(mk(OP_RD, 3'd5, 0, 0, 32'h0, "reg5"));
        tbl.push_back(mk(OP_WR, 3'd6, 32'hFFFF_FFFF, 0, 0, "wr6"));
        tbl.push_back(mk(OP_RD, REG_CTRL, 0, 0, 32'h3, "ctrl_after6"));
        tbl.push_back(mk(OP_RD, REG_DROPS, 0, 0, 32'h0, "drops0"));

        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_RD: begin
                    csr_rd(BANK, tbl[i].rg, d);
                    check(tbl[i].name, d, tbl[i].exp);
                end
                OP_RDX: begin
                    csr_rd(4'h1, tbl[i].rg, d);
                    check(tbl[i].name, d, tbl[i].exp);
                end
                OP_WR: csr_wr(tbl[i].rg, tbl[i].di);
                OP_EV: ev(tbl[i].ev);
                OP_IRQ: check(tbl[i].name, {31'b0, bus.irq},
                              tbl[i].exp);
                default: ;
            endcase
        end

        // ordering across pointer wrap
        mcount = 0;
        exp_next = 0;
        for (int i = 0; i < 20; i++) begin
            ev(64'(i));
            mcount++;
            csr_rd(BANK, REG_STATUS, d);
            check("wrap_cnt", {27'b0, d[4:0]}, 32'(mcount));
            if (i % 10 == 9) begin
                for (int k = 0; k < 10; k++) begin
                    csr_rd(BANK, REG_DATA_LO, d);
                    check("wrap_data", d, 32'(exp_next));
                    csr_wr(REG_DATA_HI, 0);
                    exp_next++;
                    mcount--;
                end
            end
        end
        csr_rd(BANK, REG_STATUS, d);
        check("wrap_end", d, 32'h10000);

        // overflow: 18 pushes into 16 slots
        for (int i = 0; i < 18; i++) ev(64'(100 + i));
        csr_rd(BANK, REG_STATUS, d);
        check("ovf_status", d, 32'h60010);
        csr_rd(BANK, REG_DROPS, d);
        check("ovf_drops", d, 32'd2);
        csr_rd(BANK, REG_DATA_LO, d);
        check("ovf_head", d, 32'd100);
        csr_wr(REG_STATUS, 32'h40000);
        csr_rd(BANK, REG_STATUS, d);
        check("ovf_clr", d, 32'h20010);
        csr_rd(BANK, REG_DROPS, d);
        check("drops_kept", d, 32'd2);

        // push and pop together while full
        bus.user_irq  = 1'b1;
        bus.user_data = 64'd500;
        csr_wr(REG_DATA_HI, 0);
        @(posedge sys_clk); #1;
        bus.user_irq = 1'b0;
        @(posedge sys_clk); #1;
        csr_rd(BANK, REG_STATUS, d);
        check("pp_status", d, 32'h20010);
        for (int k = 0; k < 16; k++) begin
            csr_rd(BANK, REG_DATA_LO, d);
            check("pp_drain", d, (k < 15) ? 32'(101 + k) : 32'd500);
            csr_wr(REG_DATA_HI, 0);
        end
        csr_rd(BANK, REG_STATUS, d);
        check("pp_empty", d, 32'h10000);

        // flush racing a push
        ev(64'd7);
        ev(64'd8);
        bus.user_irq  = 1'b1;
        bus.user_data = 64'd9;
        csr_wr(REG_CTRL, 32'h7);
        @(posedge sys_clk); #1;
        bus.user_irq = 1'b0;
        @(posedge sys_clk); #1;
        csr_rd(BANK, REG_STATUS, d);
        check("flush_status", d, 32'h10000);
        csr_rd(BANK, REG_DROPS, d);
        check("flush_drops", d, 32'd2);
        csr_rd(BANK, REG_CTRL, d);
        check("flush_ctrl", d, 32'h3);
        csr_wr(REG_DROPS, 0);
        csr_rd(BANK, REG_DROPS, d);
        check("drops_clr", d, 32'd0);

        // asynchronous reset with entries queued
        for (int i = 0; i < 5; i++) ev(64'(40 + i));
        csr_rd(BANK, REG_STATUS, d);
        check("pre_rst", d, 32'd5);
        check("pre_rst_irq", {31'b0, bus.irq}, 32'h1);
        @(posedge sys_clk);
        #3 sys_rst = 1'b0;
        #1;
        check("mid_rst_do", bus.csr_do, 32'h0);
        check("mid_rst_irq", {31'b0, bus.irq}, 32'h0);
        #2 sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        csr_rd(BANK, REG_STATUS, d);
        check("post_rst_status", d, 32'h10000);
        csr_rd(BANK, REG_CTRL, d);
        check("post_rst_ctrl", d, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
